// File: rtl/dma_bram_port.sv
// dma_bram_port: single-port data BRAM with a fixed-priority DMA/CPU arbiter.
// Optional CPU starvation guard: define DMA_BRAM_STARVE_GUARD_EN.
module dma_bram_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 13,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                dma_r_ready,
  input  logic [ADDR_W-1:0]   dma_r_addr,
  output logic                dma_r_ack,
  output logic                dma_r_valid,
  output logic [DATA_W-1:0]   dma_r_data,
  input  logic                dma_w_valid,
  input  logic [ADDR_W-1:0]   dma_w_addr,
  input  logic [DATA_W-1:0]   dma_w_data,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [DATA_W/8-1:0] cpu_sel,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ack,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  logic              cpu_first;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              rd_gnt;
  logic [IDX_W-1:0]  rd_idx;

  logic              wr_en;
  logic [NB-1:0]     wr_be;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [RD_LAT-1:0] tag_q;
  logic [RD_LAT-1:0] tag_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  // Upper address bits only alias; the array wraps on the low bits.
  generate
    if (ADDR_W > IDX_W) begin : g_wrap
      logic unused_hi;
      assign unused_hi = ^{dma_r_addr[ADDR_W-1:IDX_W],
                           dma_w_addr[ADDR_W-1:IDX_W],
                           cpu_addr[ADDR_W-1:IDX_W]};
    end
  endgenerate

`ifdef DMA_BRAM_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] stv_q;
  logic [CW-1:0] stv_d;

  assign cpu_first = cpu_req & (stv_q >= CW'(STARVE_MAX));

  always_comb begin
    stv_d = '0;
    if (cpu_req && !cpu_ack) begin
      stv_d = (stv_q == CW'(STARVE_MAX)) ? stv_q : stv_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stv_q <= '0;
    end else begin
      stv_q <= stv_d;
    end
  end
`else
  localparam int unused_stv = STARVE_MAX;

  assign cpu_first = 1'b0;
`endif

  // The stream writer can never stall, so it always wins.
  assign dma_r_ack = dma_r_ready & ~dma_w_valid & ~cpu_first;
  assign cpu_ack   = cpu_req & ~dma_w_valid &
                     (~dma_r_ready | cpu_first);

  assign cpu_wr = cpu_ack & cpu_we;
  assign cpu_rd = cpu_ack & ~cpu_we;
  assign rd_gnt = dma_r_ack | cpu_rd;
  assign rd_idx = cpu_rd ? cpu_addr[IDX_W-1:0]
                         : dma_r_addr[IDX_W-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_be   = '0;
    wr_idx  = '0;
    wr_data = '0;
    unique case (1'b1)
      dma_w_valid: begin
        wr_en   = 1'b1;
        wr_be   = '1;
        wr_idx  = dma_w_addr[IDX_W-1:0];
        wr_data = dma_w_data;
      end
      cpu_wr: begin
        wr_en   = 1'b1;
        wr_be   = cpu_sel;
        wr_idx  = cpu_addr[IDX_W-1:0];
        wr_data = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = rd_gnt;
    tag_d[0] = cpu_rd;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end

  // tag 1 marks a CPU read, 0 a DMA read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      vld_q <= '0;
      tag_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      if (rd_gnt) begin
        dat_q[0] <= mem_q[rd_idx];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign dma_r_valid = vld_q[RD_LAT-1] & ~tag_q[RD_LAT-1];
  assign cpu_rvalid  = vld_q[RD_LAT-1] &  tag_q[RD_LAT-1];
  assign dma_r_data  = dat_q[RD_LAT-1];
  assign cpu_rdata   = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_dma_bram_port.sv
// tb_dma_bram_port: directed + random stimulus vs. a word-array/queue model.
// Build with DMA_BRAM_STARVE_GUARD_EN to exercise the starvation guard.
module tb_dma_bram_port;

  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 4096;
  localparam int LAT   = 2;
  localparam int SMAX  = 8;
  localparam int NB    = DW / 8;
`ifdef DMA_BRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dma_r_ready = 1'b0;
  logic [AW-1:0] dma_r_addr = '0;
  logic          dma_r_ack;
  logic          dma_r_valid;
  logic [DW-1:0] dma_r_data;
  logic          dma_w_valid = 1'b0;
  logic [AW-1:0] dma_w_addr = '0;
  logic [DW-1:0] dma_w_data = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [NB-1:0] cpu_sel = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  dma_bram_port #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .dma_r_ready(dma_r_ready), .dma_r_addr(dma_r_addr),
    .dma_r_ack(dma_r_ack), .dma_r_valid(dma_r_valid),
    .dma_r_data(dma_r_data),
    .dma_w_valid(dma_w_valid), .dma_w_addr(dma_w_addr),
    .dma_w_data(dma_w_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata)
  );

  always #5 clk = ~clk;

  // staged inputs for the next cycle
  logic          s_rst, s_dw, s_dr, s_cr, s_cwe;
  logic [AW-1:0] s_dwa, s_dra, s_ca;
  logic [DW-1:0] s_dwd, s_cwd;
  logic [NB-1:0] s_sel;

  typedef struct {
    int          due;
    bit          cpu;
    logic [DW-1:0] d;
    logic [NB-1:0] kn;
  } ret_t;

  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_kn  [DEPTH];
  ret_t          q[$];
  int            m_stv = 0;
  int            cyc = 0;
  bit            armed = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h",
                  tag, cyc, got, exp);
  endtask

  function automatic logic [DW-1:0] bmask(input logic [NB-1:0] k);
    logic [DW-1:0] m;
    for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic clr();
    s_rst = 0; s_dw = 0; s_dr = 0; s_cr = 0; s_cwe = 0;
    s_dwa = '0; s_dra = '0; s_ca = '0;
    s_dwd = '0; s_cwd = '0; s_sel = '0;
  endtask

  task automatic tick();
    bit            e_dv, e_cv, g_w, g_r, g_c, first;
    logic [DW-1:0] e_d;
    logic [NB-1:0] e_k;
    ret_t          r;
    int            ix;
    e_dv = 0; e_cv = 0; e_d = '0; e_k = '0;
    @(negedge clk);
    if (armed) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        r    = q.pop_front();
        e_dv = !r.cpu;
        e_cv = r.cpu;
        e_d  = r.d;
        e_k  = r.kn;
      end
      check("dma_r_valid", dma_r_valid, e_dv);
      check("cpu_rvalid", cpu_rvalid, e_cv);
      if (e_dv && e_k != 0)
        check("dma_r_data", dma_r_data & bmask(e_k),
              e_d & bmask(e_k));
      if (e_cv && e_k != 0)
        check("cpu_rdata", cpu_rdata & bmask(e_k),
              e_d & bmask(e_k));
    end
    rst = s_rst;
    dma_w_valid = s_dw; dma_w_addr = s_dwa; dma_w_data = s_dwd;
    dma_r_ready = s_dr; dma_r_addr = s_dra;
    cpu_req = s_cr; cpu_we = s_cwe; cpu_sel = s_sel;
    cpu_addr = s_ca; cpu_wdata = s_cwd;
    #1;
    first = GUARD && s_cr && (m_stv >= SMAX);
    g_w = 0; g_r = 0; g_c = 0;
    if (s_dw)      g_w = 1;
    else if (first) g_c = 1;
    else if (s_dr) g_r = 1;
    else if (s_cr) g_c = 1;
    if (armed) begin
      check("dma_r_ack", dma_r_ack, g_r);
      check("cpu_ack", cpu_ack, g_c);
    end
    if (g_w) begin
      ix = widx(s_dwa);
      m_mem[ix] = s_dwd;
      m_kn[ix]  = '1;
    end
    if (g_c && s_cwe) begin
      ix = widx(s_ca);
      for (int b = 0; b < NB; b++) if (s_sel[b]) begin
        m_mem[ix][8*b +: 8] = s_cwd[8*b +: 8];
        m_kn[ix][b] = 1'b1;
      end
    end
    if (!s_rst && (g_r || (g_c && !s_cwe))) begin
      ix = g_r ? widx(s_dra) : widx(s_ca);
      r.due = cyc + LAT;
      r.cpu = g_c;
      r.d   = m_mem[ix];
      r.kn  = m_kn[ix];
      q.push_back(r);
    end
    if (s_cr && !g_c) m_stv = (m_stv < SMAX) ? m_stv + 1 : SMAX;
    else m_stv = 0;
    if (s_rst) begin
      q.delete();
      m_stv = 0;
      armed = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic dwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr(); s_dw = 1; s_dwa = a; s_dwd = d; tick();
  endtask

  task automatic drd(input logic [AW-1:0] a);
    clr(); s_dr = 1; s_dra = a; tick();
  endtask

  task automatic cwr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [NB-1:0] sel);
    clr(); s_cr = 1; s_cwe = 1; s_ca = a; s_cwd = d; s_sel = sel;
    tick();
  endtask

  task automatic crd(input logic [AW-1:0] a);
    clr(); s_cr = 1; s_ca = a; tick();
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | AW'(DEPTH);
    return a;
  endfunction

  initial begin
    int first_ack;
    for (int i = 0; i < DEPTH; i++) m_kn[i] = '0;

    clr(); s_rst = 1; tick(); tick();
    idle(1);
    check("rst_dma_r_data", dma_r_data, '0);
    check("rst_cpu_rdata", cpu_rdata, '0);
    check("rst_dma_r_valid", dma_r_valid, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);

    for (int i = 0; i < 4; i++)
      dwr(AW'(13'h100 + i), 32'hA5A5_0000 + i);
    for (int i = 0; i < 4; i++) drd(AW'(13'h100 + i));
    idle(3);

    clr();
    s_dw = 1; s_dwa = 13'h010; s_dwd = 32'hC0DE_0010;
    s_dr = 1; s_dra = 13'h010;
    tick();
    clr(); s_dr = 1; s_dra = 13'h010; tick();
    idle(3);

    cwr(13'h020, 32'hFFFF_FFFF, 4'hF);
    cwr(13'h020, 32'h1234_5678, 4'b0011);
    crd(13'h020);
    idle(3);

    dwr(13'h030, 32'h3030_3030);
    idle(1);
    drd(13'h030);
    clr(); s_rst = 1; tick();
    idle(LAT + 2);
    drd(13'h030);
    idle(3);

    dwr(13'h0005, 32'hDEAD_BEEF);
    drd(13'h1005);
    idle(3);

    first_ack = -1;
    for (int i = 0; i < 12; i++) begin
      clr(); s_dr = 1; s_dra = 13'h100; s_cr = 1; s_ca = 13'h020;
      tick();
      if (cpu_ack && first_ack < 0) first_ack = i;
    end
    check("starve_first_cpu_ack", first_ack, GUARD ? 8 : -1);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      clr();
      s_rst = ($urandom_range(0, 99) == 0);
      if (!s_rst) begin
        s_dw  = ($urandom_range(0, 3) == 0);
        s_dwa = raddr();
        s_dwd = $urandom;
        s_dr  = ($urandom_range(0, 2) == 0);
        s_dra = raddr();
        s_cr  = ($urandom_range(0, 1) == 0);
        s_cwe = ($urandom_range(0, 1) == 0);
        s_ca  = raddr();
        s_cwd = $urandom;
        s_sel = NB'($urandom_range(0, 15));
      end
      tick();
    end
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
